// File: rtl/debounced_btn_core_pkg.sv
// Shared definitions for the debounced button MMIO core: register word type
// and the slot-relative word addresses of the four registers.
package btn_core_pkg;

  typedef logic [31:0] word_t;

  localparam logic [4:0] ADDR_RAW   = 5'd0;
  localparam logic [4:0] ADDR_LEVEL = 5'd1;
  localparam logic [4:0] ADDR_EDGE  = 5'd2;
  localparam logic [4:0] ADDR_MASK  = 5'd3;

  // True when a slot address selects one of the implemented registers.
  function automatic logic is_mapped(input logic [4:0] a);
    return (a <= ADDR_MASK);
  endfunction

endpackage

// File: rtl/debounced_btn_core_if.sv
// MMIO slot bus between the slot controller (master) and a core (slave).
// Handshake: single-cycle access. A write takes effect on the clock edge where
// cs and write are both high; rd_data is combinational from addr alone, valid
// in the same cycle, and reads never change state (read is informational).
interface debounced_btn_core_if;
  import btn_core_pkg::*;

  logic       cs;
  logic       read;
  logic       write;
  logic [4:0] addr;
  word_t      wr_data;
  word_t      rd_data;

  modport master (
    output cs,
    output read,
    output write,
    output addr,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  cs,
    input  read,
    input  write,
    input  addr,
    input  wr_data,
    output rd_data
  );

endinterface

// File: rtl/debounced_btn_core_debounce_bit.sv
// One input channel: two-flop synchronizer followed by a stability counter.
// The debounced level only follows the synchronized input after it has
// differed from the level for DB_TICKS consecutive cycles; any return to the
// current level restarts the count.
module debounce_bit #(
  parameter int DB_TICKS = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_raw,
  output logic o_level
);

  localparam int CW = $clog2(DB_TICKS);
  localparam logic [CW-1:0] TERM = CW'(DB_TICKS - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sync <= 2'b00;
    else       r_sync <= {r_sync[0], i_btn};
  end

  // Count cycles of disagreement; adopt the new level at the terminal count.
  // The counter is cleared at the terminal count, so it can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync[1] == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == TERM) begin
      r_level <= r_sync[1];
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_raw   = r_sync[1];
  assign o_level = r_level;

endmodule

// File: rtl/debounced_btn_core.sv
// Debounced button/switch input core for the MMIO slot array.
// Registers: 0 RAW (RO), 1 LEVEL (RO), 2 EDGE (sticky rising edges, W1C),
// 3 MASK (RW interrupt mask). Optional feature macro: BTN_CORE_IRQ_EN enables
// MASK and a registered level interrupt irq = |(EDGE & MASK); without it MASK
// reads 0, writes to it are ignored and irq is tied low.
module debounced_btn_core
  import btn_core_pkg::*;
#(
  parameter int W        = 4,
  parameter int DB_TICKS = 2_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  debounced_btn_core_if.slave        bus,
  input  logic [W-1:0]               btn_in,
  output logic                       irq
);

  logic [W-1:0] w_raw;
  logic [W-1:0] w_level;
  logic [W-1:0] w_rise;
  logic [W-1:0] w_clr;
  logic [W-1:0] w_mask;
  logic         w_wr;
  logic         w_unused;
  word_t        w_rd;

  logic [W-1:0] r_level_q;
  logic [W-1:0] r_edge;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      debounce_bit #(
        .DB_TICKS (DB_TICKS)
      ) u_db (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (btn_in[gi]),
        .o_raw   (w_raw[gi]),
        .o_level (w_level[gi])
      );
    end
  endgenerate

  assign w_wr   = bus.cs & bus.write;
  assign w_rise = w_level & ~r_level_q;
  assign w_clr  = (w_wr && bus.addr == ADDR_EDGE) ? bus.wr_data[W-1:0] : '0;

  // Reads have no side effects, and upper write-data bits are don't-care.
  assign w_unused = ^{bus.read, bus.wr_data};

  // Delayed copy of the debounced level for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_level_q <= '0;
    else       r_level_q <= w_level;
  end

  // Sticky rising-edge flags; a new edge beats a simultaneous W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_edge <= '0;
    else       r_edge <= (r_edge & ~w_clr) | w_rise;
  end

`ifdef BTN_CORE_IRQ_EN
  logic [W-1:0] r_mask;
  logic         r_irq;

  // Interrupt mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            r_mask <= '0;
    else if (w_wr && bus.addr == ADDR_MASK) r_mask <= bus.wr_data[W-1:0];
  end

  // Registered interrupt: follows pending-and-enabled flags one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= |(r_edge & r_mask);
  end

  assign w_mask = r_mask;
  assign irq    = r_irq;
`else
  assign w_mask = '0;
  assign irq    = 1'b0;
`endif

  // Combinational read mux, decoded from addr only.
  always_comb begin
    w_rd = '0;
    if (is_mapped(bus.addr)) begin
      case (bus.addr)
        ADDR_RAW:   w_rd[W-1:0] = w_raw;
        ADDR_LEVEL: w_rd[W-1:0] = w_level;
        ADDR_EDGE:  w_rd[W-1:0] = r_edge;
        ADDR_MASK:  w_rd[W-1:0] = w_mask;
        default:    w_rd = '0;
      endcase
    end
  end

  assign bus.rd_data = w_rd;

endmodule

// File: tb/tb_debounced_btn_core.sv
// Directed bench for debounced_btn_core with W=4, DB_TICKS=8.
// Inputs change 1 time unit after a rising edge; outputs are read 2 units
// after a rising edge, so "N cycles later" means after N further clock edges.
module tb_debounced_btn_core;
  import btn_core_pkg::*;

  localparam int W  = 4;
  localparam int DB = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] btn_in;
  logic         irq;

  int n_tests = 0;
  int n_fail  = 0;

  debounced_btn_core_if bus ();

  debounced_btn_core #(
    .W        (W),
    .DB_TICKS (DB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .btn_in (btn_in),
    .irq    (irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.cs = 0; bus.read = 0; bus.write = 0; bus.addr = '0; bus.wr_data = '0;
    btn_in = '0;
    reset  = 1'b1;
    tick(2);
    reset  = 1'b0;
    tick(1);
  endtask

  task automatic rd(input logic [4:0] a, output word_t v);
    bus.addr = a;
    bus.read = 1'b1;
    #1;
    v = bus.rd_data;
    bus.read = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input word_t d);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
    tick(1);
    bus.cs = 1'b0; bus.write = 1'b0; bus.wr_data = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    word_t v;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      rd(5'(a), v);
      n_tests++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d got %h exp %h", a, v, 32'h0); end
    end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", irq); end

    // reset in the middle of a debounce
    btn_in = 4'b0001;
    tick(5);
    reset = 1'b1;
    #1;
    rd(ADDR_LEVEL, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL midreset_level got %h exp %h", v, 32'h0); end
    rd(ADDR_EDGE, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL midreset_edge got %h exp %h", v, 32'h0); end
    tick(2);
    reset = 1'b0;
    tick(9);
    rd(ADDR_LEVEL, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL midreset_level_early got %h exp %h", v, 32'h0); end
    tick(1);
    rd(ADDR_LEVEL, v);
    n_tests++;
    if (v !== 32'h1) begin n_fail++; $display("FAIL midreset_level_10 got %h exp %h", v, 32'h1); end
    tick(1);
    rd(ADDR_EDGE, v);
    n_tests++;
    if (v !== 32'h1) begin n_fail++; $display("FAIL midreset_edge_11 got %h exp %h", v, 32'h1); end
  endtask

  task automatic test_clean_press();
    word_t v;
    do_reset();
    btn_in = 4'b0100;
    tick(1);
    rd(ADDR_RAW, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL press_raw_1 got %h exp %h", v, 32'h0); end
    tick(1);
    rd(ADDR_RAW, v);
    n_tests++;
    if (v !== 32'h4) begin n_fail++; $display("FAIL press_raw_2 got %h exp %h", v, 32'h4); end
    tick(7);
    rd(ADDR_LEVEL, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL press_level_9 got %h exp %h", v, 32'h0); end
    tick(1);
    rd(ADDR_LEVEL, v);
    n_tests++;
    if (v !== 32'h4) begin n_fail++; $display("FAIL press_level_10 got %h exp %h", v, 32'h4); end
    rd(ADDR_EDGE, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL press_edge_10 got %h exp %h", v, 32'h0); end
    tick(1);
    rd(ADDR_EDGE, v);
    n_tests++;
    if (v !== 32'h4) begin n_fail++; $display("FAIL press_edge_11 got %h exp %h", v, 32'h4); end
    // release
    btn_in = 4'b0000;
    tick(9);
    rd(ADDR_LEVEL, v);
    n_tests++;
    if (v !== 32'h4) begin n_fail++; $display("FAIL release_level_9 got %h exp %h", v, 32'h4); end
    tick(1);
    rd(ADDR_LEVEL, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL release_level_10 got %h exp %h", v, 32'h0); end
    tick(2);
    rd(ADDR_EDGE, v);
    n_tests++;
    if (v !== 32'h4) begin n_fail++; $display("FAIL release_edge_kept got %h exp %h", v, 32'h4); end
  endtask

  task automatic test_bounce();
    word_t v;
    int    bad;
    do_reset();
    bad = 0;
    for (int t = 0; t < 30; t++) begin
      if (t % 3 == 0) btn_in[1] = ~btn_in[1];
      tick(1);
      rd(ADDR_LEVEL, v);
      if (v[1] !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL bounce_level_stable got %0d bad cycles exp 0", bad); end
    btn_in[1] = 1'b1;
    tick(9);
    rd(ADDR_LEVEL, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL bounce_level_9 got %h exp %h", v, 32'h0); end
    tick(1);
    rd(ADDR_LEVEL, v);
    n_tests++;
    if (v !== 32'h2) begin n_fail++; $display("FAIL bounce_level_10 got %h exp %h", v, 32'h2); end
    tick(3);
    rd(ADDR_EDGE, v);
    n_tests++;
    if (v !== 32'h2) begin n_fail++; $display("FAIL bounce_edge got %h exp %h", v, 32'h2); end
  endtask

  task automatic test_w1c();
    word_t v;
    do_reset();
    btn_in = 4'b0110;
    tick(11);
    rd(ADDR_EDGE, v);
    n_tests++;
    if (v !== 32'h6) begin n_fail++; $display("FAIL w1c_setup got %h exp %h", v, 32'h6); end
    wr(ADDR_EDGE, 32'h2);
    rd(ADDR_EDGE, v);
    n_tests++;
    if (v !== 32'h4) begin n_fail++; $display("FAIL w1c_clear_bit1 got %h exp %h", v, 32'h4); end
    wr(ADDR_EDGE, 32'h0);
    rd(ADDR_EDGE, v);
    n_tests++;
    if (v !== 32'h4) begin n_fail++; $display("FAIL w1c_zero got %h exp %h", v, 32'h4); end
    // edge on bit 3 sets at the 11th edge; W1C of bit 3 lands on that same edge
    btn_in[3] = 1'b1;
    tick(10);
    wr(ADDR_EDGE, 32'h8);
    rd(ADDR_EDGE, v);
    n_tests++;
    if (v !== 32'hC) begin n_fail++; $display("FAIL w1c_set_wins got %h exp %h", v, 32'hC); end
    wr(ADDR_EDGE, 32'h8);
    rd(ADDR_EDGE, v);
    n_tests++;
    if (v !== 32'h4) begin n_fail++; $display("FAIL w1c_clear_bit3 got %h exp %h", v, 32'h4); end
  endtask

  task automatic test_irq();
    word_t v;
    do_reset();
    wr(ADDR_MASK, 32'h4);
    rd(ADDR_MASK, v);
`ifdef BTN_CORE_IRQ_EN
    n_tests++;
    if (v !== 32'h4) begin n_fail++; $display("FAIL irq_mask_rd got %h exp %h", v, 32'h4); end
    btn_in = 4'b0001;
    tick(12);
    rd(ADDR_EDGE, v);
    n_tests++;
    if (v !== 32'h1 || irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_unmasked got edge %h irq %b exp edge 1 irq 0", v, irq);
    end
    btn_in = 4'b0101;
    tick(11);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_before got %b exp 0", irq); end
    tick(1);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_assert got %b exp 1", irq); end
    wr(ADDR_EDGE, 32'h4);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold_after_w1c got %b exp 1", irq); end
    tick(1);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_deassert got %b exp 0", irq); end
`else
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL irq_mask_absent got %h exp %h", v, 32'h0); end
    btn_in = 4'b0100;
    tick(13);
    rd(ADDR_EDGE, v);
    n_tests++;
    if (v !== 32'h4 || irq !== 1'b0) begin
      n_fail++; $display("FAIL irq_tied got edge %h irq %b exp edge 4 irq 0", v, irq);
    end
`endif
  endtask

  task automatic test_decode();
    word_t v;
    do_reset();
    btn_in = 4'b1001;
    tick(12);
    rd(5'd5, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL decode_addr5 got %h exp %h", v, 32'h0); end
    rd(5'd31, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL decode_addr31 got %h exp %h", v, 32'h0); end
    rd(5'd4, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL decode_addr4 got %h exp %h", v, 32'h0); end
    wr(5'd7, 32'hFFFF_FFFF);
    wr(ADDR_RAW, 32'hFFFF_FFFF);
    wr(ADDR_LEVEL, 32'hFFFF_FFFF);
    rd(ADDR_EDGE, v);
    n_tests++;
    if (v !== 32'h9) begin n_fail++; $display("FAIL decode_edge_kept got %h exp %h", v, 32'h9); end
    rd(ADDR_MASK, v);
    n_tests++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL decode_mask_kept got %h exp %h", v, 32'h0); end
    rd(ADDR_LEVEL, v);
    n_tests++;
    if (v !== 32'h9) begin n_fail++; $display("FAIL decode_level got %h exp %h", v, 32'h9); end
    rd(ADDR_RAW, v);
    n_tests++;
    if (v !== 32'h9) begin n_fail++; $display("FAIL decode_raw got %h exp %h", v, 32'h9); end
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL decode_irq got %b exp 0", irq); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    btn_in = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_w1c();
    test_irq();
    test_decode();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
